// File: rtl/monty_pkg.sv
// Shared constants and state encoding for the Montgomery-domain entry converter.
package monty_pkg;

  localparam int MONTY_W     = 64;
  localparam int MONTY_K     = 68;
  localparam int MONTY_WORD  = 17;
  localparam int MONTY_CNT_W = $clog2(MONTY_K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } monty_enc_state_t;

endpackage

// File: rtl/monty_dbl_step.sv
// One modular doubling: y = 2x mod q, for x < q and odd q > 2^(W-1).
module monty_dbl_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] q,
  output logic [W-1:0] y
);

  logic [W:0] t;
  logic       ge;

  always_comb begin
    t  = {x, 1'b0};
    // t >= q whenever the carry bit is set, since q < 2^W
    ge = t[W] | (t[W-1:0] >= q);
    // true difference is below q, so wrapping W-bit subtraction is exact
    y  = ge ? (t[W-1:0] - q) : t[W-1:0];
  end

endmodule

// File: rtl/monty_enc.sv
// Converts a (mod q) into Montgomery form a*2^K mod q by K iterated doublings.
//
// state | meaning
// IDLE  | waiting for an operand; in_ready high
// RUN   | one modular doubling per cycle, cnt = iteration index
// DONE  | result held on C with out_valid until out_ready
module monty_enc
  import monty_pkg::*;
#(
  parameter int W = MONTY_W,
  parameter int K = MONTY_K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] q,
  input  logic [W-1:0] a,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] C,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CNT_W = $clog2(K);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  monty_enc_state_t state, state_nx;

  logic [W-1:0]     qr;
  logic [W-1:0]     x;
  logic [W-1:0]     x_dbl;
  logic [W-1:0]     a_norm;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     c_q;

  monty_dbl_step #(.W(W)) u_dbl (
    .x (x),
    .q (qr),
    .y (x_dbl)
  );

  // a < 2q is assumed, so one conditional subtraction lands in [0, q)
  assign a_norm = (a >= q) ? (a - q) : a;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (cnt == CNT_LAST) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      qr    <= '0;
      x     <= '0;
      cnt   <= '0;
      c_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            qr  <= q;
            x   <= a_norm;
            cnt <= '0;
          end
        end
        RUN: begin
          x   <= x_dbl;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) c_q <= x_dbl;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign C         = c_q;

endmodule
